multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the 16-bit RISC datapath. Latches each 32-bit instruction from instruction memory, decodes it, and steps the datapath through FETCH/DECODE/EXEC/MEM/WB. It drives the PC-adjust select, register-file addresses and write enable, ALU source and operation, and the data-memory handshake. It sits beside `control`, replacing its free-running per-edge decode with an explicit state machine.

---
 rtl/risc_pkg.sv | 65 ++++++
 rtl/opcode_decode.sv | 68 ++++++
 rtl/multicycle_ctrl.sv | 172 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// risc_pkg: shared encodings for the 16-bit RISC control path.
// Opcode and funct values, FSM states, PC-adjust selects and the
// instruction field bit positions used by multicycle_ctrl and opcode_decode.
package risc_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned FUNCT_W = 6;

    // Instruction field positions (LSB of each field)
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_LSB   = 0;

    // Padding bits between fields; carry no meaning
    localparam int unsigned RSV_HI_BIT = 25;
    localparam int unsigned RSV_LO_BIT = 20;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PC_INC    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_sel_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_HALT,
        CLS_NOP
    } op_class_t;

    typedef enum logic [1:0] {
        DEST_NONE,
        DEST_RD,
        DEST_RT
    } dest_sel_t;

endpackage

// File: rtl/opcode_decode.sv
// opcode_decode: combinational opcode/funct -> instruction class,
// ALU source, ALU operation, destination select, mem_to_reg and legality.
module opcode_decode
    import risc_pkg::*;
#(
    parameter int unsigned OPW = OP_W
) (
    input  logic [OPW-1:0]     opcode,
    input  logic [FUNCT_W-1:0] funct,
    output op_class_t          op_class,
    output logic               alu_src,
    output dest_sel_t          dest_sel,
    output logic               mem_to_reg,
    output logic               legal,
    output logic [OPW-1:0]     alu_op
);

    // Classify the opcode; undefined opcodes fall through as illegal NOPs
    always_comb begin
        op_class   = CLS_NOP;
        alu_src    = 1'b0;
        dest_sel   = DEST_NONE;
        mem_to_reg = 1'b0;
        legal      = 1'b0;
        alu_op     = FUNCT_ADD;
        case (opcode)
            OP_R: begin
                op_class = CLS_ALU;
                dest_sel = DEST_RD;
                legal    = 1'b1;
                alu_op   = funct;
            end
            OP_ADDI: begin
                op_class = CLS_ALU;
                alu_src  = 1'b1;
                dest_sel = DEST_RT;
                legal    = 1'b1;
            end
            OP_LW: begin
                op_class   = CLS_LOAD;
                alu_src    = 1'b1;
                dest_sel   = DEST_RT;
                mem_to_reg = 1'b1;
                legal      = 1'b1;
            end
            OP_SW: begin
                op_class = CLS_STORE;
                alu_src  = 1'b1;
                legal    = 1'b1;
            end
            OP_BEQ: begin
                op_class = CLS_BRANCH;
                legal    = 1'b1;
                alu_op   = FUNCT_SUB;
            end
            OP_J: begin
                op_class = CLS_JUMP;
                legal    = 1'b1;
            end
            OP_HALT: begin
                op_class = CLS_HALT;
                legal    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC
// datapath. Holds the instruction register and steps the datapath strobes.
// Optional: define MULTICYCLE_ILLEGAL_TRAP_EN to halt on undefined opcodes;
// otherwise they retire as NOPs (illegal_op still latches).
module multicycle_ctrl
    import risc_pkg::*;
#(
    parameter int unsigned OPW = OP_W,
    parameter int unsigned AW  = REG_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [31:0]    instr,
    input  logic           instr_valid,
    input  logic           mem_ready,
    input  logic           alu_zero,
    output logic           ir_load,
    output logic           pc_write,
    output logic [1:0]     pc_sel,
    output logic [AW-1:0]  rs,
    output logic [AW-1:0]  rt,
    output logic [AW-1:0]  rd,
    output logic [15:0]    imm,
    output logic [OPW-1:0] alu_op,
    output logic           alu_src,
    output logic           reg_write,
    output logic           mem_read,
    output logic           mem_write,
    output logic           mem_to_reg,
    output logic           halted,
    output logic           illegal_op,
    output logic [2:0]     state_dbg
);

    state_t           state;
    logic [OPW-1:0]   ir_op;
    logic [AW-1:0]    ir_rs;
    logic [AW-1:0]    ir_rt;
    logic [IMM_W-1:0] ir_imm;
    logic             illegal_q;

    op_class_t        dec_class;
    logic             dec_alu_src;
    dest_sel_t        dec_dest;
    logic             dec_mem_to_reg;
    logic             dec_legal;

    // Padding bits between fields are never stored
    logic             unused_rsvd;
    assign unused_rsvd = ^{instr[RSV_HI_BIT], instr[RSV_LO_BIT]};

    opcode_decode #(
        .OPW (OPW)
    ) u_decode (
        .opcode     (ir_op),
        .funct      (ir_imm[FUNCT_LSB +: FUNCT_W]),
        .op_class   (dec_class),
        .alu_src    (dec_alu_src),
        .dest_sel   (dec_dest),
        .mem_to_reg (dec_mem_to_reg),
        .legal      (dec_legal),
        .alu_op     (alu_op)
    );

    // Sequencer state, instruction register and sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            ir_op     <= '0;
            ir_rs     <= '0;
            ir_rt     <= '0;
            ir_imm    <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (instr_valid) begin
                        ir_op  <= instr[OP_LSB +: OPW];
                        ir_rs  <= instr[RS_LSB +: AW];
                        ir_rt  <= instr[RT_LSB +: AW];
                        ir_imm <= instr[IMM_LSB +: IMM_W];
                        state  <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!dec_legal) begin
                        illegal_q <= 1'b1;
                    end
                    if (dec_class == CLS_HALT) begin
                        state <= ST_HALT;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                    end else if (!dec_legal) begin
                        state <= ST_HALT;
`else
                    end else if (!dec_legal) begin
                        // Retire as a NOP: WB advances the PC, reg_write stays low
                        state <= ST_WB;
`endif
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (dec_class)
                        CLS_LOAD, CLS_STORE:  state <= ST_MEM;
                        CLS_BRANCH, CLS_JUMP: state <= ST_FETCH;
                        default:              state <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        state <= (dec_class == CLS_LOAD) ? ST_WB : ST_FETCH;
                    end
                end
                ST_WB:   state <= ST_FETCH;
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Datapath strobes decoded from the registered state and IR
    always_comb begin
        ir_load    = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = PC_INC;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        case (state)
            ST_FETCH: begin
                // Qualified by rst_n so nothing pulses while reset is held
                ir_load = instr_valid & rst_n;
            end
            ST_EXEC: begin
                alu_src = dec_alu_src;
                if (dec_class == CLS_BRANCH) begin
                    pc_write = 1'b1;
                    pc_sel   = alu_zero ? PC_BRANCH : PC_INC;
                end else if (dec_class == CLS_JUMP) begin
                    pc_write = 1'b1;
                    pc_sel   = PC_JUMP;
                end
            end
            ST_MEM: begin
                alu_src   = dec_alu_src;
                mem_read  = (dec_class == CLS_LOAD);
                mem_write = (dec_class == CLS_STORE);
                if (mem_ready && dec_class == CLS_STORE) begin
                    pc_write = 1'b1;
                end
            end
            ST_WB: begin
                reg_write  = (dec_dest != DEST_NONE);
                mem_to_reg = dec_mem_to_reg;
                pc_write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign rs         = ir_rs;
    assign rt         = ir_rt;
    assign rd         = ir_imm[RD_LSB +: AW];
    assign imm        = ir_imm;
    assign halted     = (state == ST_HALT);
    assign illegal_op = illegal_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction stream against a per-instruction
// reference model (cycle count, strobe counts, pc_sel, destination, flags).
module tb_multicycle_ctrl;

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_ADDI = 6'h08;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_HLT  = 6'h3F;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic        ir_load, pc_write, alu_src, reg_write, mem_read, mem_write;
    logic        mem_to_reg, halted, illegal_op;
    logic [1:0]  pc_sel;
    logic [3:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  alu_op;
    logic [2:0]  state_dbg;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic        model_illegal = 1'b0;

    multicycle_ctrl #(
        .OPW (6),
        .AW  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .mem_ready   (mem_ready),
        .alu_zero    (alu_zero),
        .ir_load     (ir_load),
        .pc_write    (pc_write),
        .pc_sel      (pc_sel),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm         (imm),
        .alu_op      (alu_op),
        .alu_src     (alu_src),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OPC_R, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ, OPC_J, OPC_HLT};
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] s,
                                       input logic [3:0] t, input logic [15:0] im);
        return {op, 1'b0, s, 1'b0, t, im};
    endfunction

    // Hold reset with instr_valid high, check the reset outputs, release mid-cycle
    task automatic do_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        mem_ready   = 1'b1;
        alu_zero    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'(state_dbg), 64'd0);
        check("rst_strobes", 64'({ir_load, pc_write, reg_write, mem_read, mem_write,
                                  mem_to_reg, alu_src, halted, illegal_op}), 64'd0);
        check("rst_fields", 64'({pc_sel, rs, rt, rd, imm, alu_op}), 64'd0);
        instr_valid = 1'b0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;
        model_illegal = 1'b0;
    endtask

    // Run one instruction from FETCH to its retirement and compare with the model
    task automatic run_instr(input logic [31:0] word, input int unsigned fv,
                             input int unsigned mw, input logic az);
        logic [5:0]  op;
        int unsigned cyc, mem_seen, n_irl, irl_at, n_pcw, n_rw, n_mr, n_mw, n_both, n_rw_pcw;
        logic [1:0]  pcsel_obs;
        logic [3:0]  dest_obs;
        logic        m2r_obs, exec_seen, alusrc_obs, done, halt_obs;
        logic [5:0]  aluop_obs;
        logic        legal, halts, exp_rw, exp_exec, exp_alusrc;
        int unsigned exp_cyc;
        logic [1:0]  exp_pcsel;
        logic [3:0]  exp_dest;
        logic [5:0]  exp_aluop;

        op = word[31:26];
        cyc = 0; mem_seen = 0; n_irl = 0; irl_at = 0; n_pcw = 0; n_rw = 0;
        n_mr = 0; n_mw = 0; n_both = 0; n_rw_pcw = 0;
        pcsel_obs = '0; dest_obs = '0; m2r_obs = 1'b0; exec_seen = 1'b0;
        alusrc_obs = 1'b0; aluop_obs = '0; done = 1'b0; halt_obs = 1'b0;
        instr    = word;
        alu_zero = az;
        while (!done && cyc < 64) begin
            instr_valid = (cyc >= fv);
            mem_ready   = (mem_seen >= mw);
            @(negedge clk);
            if (ir_load) begin n_irl++; irl_at = cyc; end
            if (mem_read) begin n_mr++; mem_seen++; end
            if (mem_write) begin n_mw++; mem_seen++; end
            if (reg_write && mem_write) n_both++;
            if (reg_write) begin
                n_rw++;
                dest_obs = (op == OPC_R) ? rd : rt;
                m2r_obs  = mem_to_reg;
                if (pc_write) n_rw_pcw++;
            end
            if (state_dbg == 3'd2 && !exec_seen) begin
                exec_seen  = 1'b1;
                aluop_obs  = alu_op;
                alusrc_obs = alu_src;
            end
            if (pc_write) begin n_pcw++; pcsel_obs = pc_sel; done = 1'b1; end
            if (halted) begin halt_obs = 1'b1; done = 1'b1; end
            @(posedge clk);
            #1;
            cyc++;
        end

        // Reference model
        legal = is_legal(op);
        halts = (op == OPC_HLT) || (!legal && TRAP);
        model_illegal = model_illegal | !legal;
        if (halts || !legal)                     exp_cyc = 3 + fv;
        else if (op == OPC_LW)                   exp_cyc = 5 + fv + mw;
        else if (op == OPC_SW)                   exp_cyc = 4 + fv + mw;
        else if (op == OPC_BEQ || op == OPC_J)   exp_cyc = 3 + fv;
        else                                     exp_cyc = 4 + fv;
        exp_pcsel  = (op == OPC_BEQ) ? (az ? 2'b01 : 2'b00) : (op == OPC_J) ? 2'b10 : 2'b00;
        exp_rw     = op inside {OPC_R, OPC_ADDI, OPC_LW};
        exp_dest   = (op == OPC_R) ? word[14:11] : word[19:16];
        exp_exec   = legal && (op != OPC_HLT);
        exp_aluop  = (op == OPC_R) ? word[5:0] : (op == OPC_BEQ) ? 6'h22 : 6'h20;
        exp_alusrc = op inside {OPC_ADDI, OPC_LW, OPC_SW};

        check($sformatf("cycles op=%0h", op), 64'(cyc), 64'(exp_cyc));
        check($sformatf("ir_load_cnt op=%0h", op), 64'(n_irl), 64'd1);
        check($sformatf("ir_load_at op=%0h", op), 64'(irl_at), 64'(fv));
        check($sformatf("pc_write_cnt op=%0h", op), 64'(n_pcw), 64'(!halts));
        if (!halts) check($sformatf("pc_sel op=%0h", op), 64'(pcsel_obs), 64'(exp_pcsel));
        check($sformatf("reg_write_cnt op=%0h", op), 64'(n_rw), 64'(exp_rw));
        if (exp_rw) begin
            check($sformatf("dest op=%0h", op), 64'(dest_obs), 64'(exp_dest));
            check($sformatf("mem_to_reg op=%0h", op), 64'(m2r_obs), 64'(op == OPC_LW));
            check($sformatf("wb_with_pc op=%0h", op), 64'(n_rw_pcw), 64'd1);
        end
        check($sformatf("mem_read_cyc op=%0h", op), 64'(n_mr), 64'((op == OPC_LW) ? mw + 1 : 0));
        check($sformatf("mem_write_cyc op=%0h", op), 64'(n_mw), 64'((op == OPC_SW) ? mw + 1 : 0));
        check($sformatf("rw_mw_overlap op=%0h", op), 64'(n_both), 64'd0);
        check($sformatf("exec_visit op=%0h", op), 64'(exec_seen), 64'(exp_exec));
        if (exec_seen) begin
            check($sformatf("alu_op op=%0h", op), 64'(aluop_obs), 64'(exp_aluop));
            check($sformatf("alu_src op=%0h", op), 64'(alusrc_obs), 64'(exp_alusrc));
        end
        check($sformatf("halted op=%0h", op), 64'(halt_obs), 64'(halts));
        check($sformatf("illegal_op op=%0h", op), 64'(illegal_op), 64'(model_illegal));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0]  pool [6];
        logic [5:0]  op;
        logic [31:0] word;
        logic        seen;
        int unsigned k;
        int unsigned strobe_hits, halt_lows;

        pool = '{OPC_R, OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ, OPC_J};
        do_reset();

        // Random instruction stream
        for (int n = 0; n < 40; n++) begin
            op = pool[$urandom_range(0, 5)];
            if (!TRAP && $urandom_range(0, 5) == 0) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end
            word = $urandom;
            word[31:26] = op;
            run_instr(word, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
        end

        // Reset asserted while a load is waiting in MEM
        instr       = mk(OPC_LW, 4'd1, 4'd5, 16'd4);
        instr_valid = 1'b1;
        mem_ready   = 1'b0;
        seen        = 1'b0;
        k           = 0;
        while (!seen && k < 10) begin
            @(negedge clk);
            if (mem_read) seen = 1'b1;
            k++;
        end
        check("rst_mid_lw_reached", 64'(seen), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_state", 64'(state_dbg), 64'd0);
        check("rst_mid_strobes", 64'({ir_load, pc_write, reg_write, mem_read, mem_write,
                                      mem_to_reg, halted}), 64'd0);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_illegal = 1'b0;
        check("rst_mid_illegal", 64'(illegal_op), 64'd0);

        // Directed: ADD r3 = r1 + r2, then LW r5,4(r1) with three wait cycles
        run_instr(mk(OPC_R, 4'd1, 4'd2, {1'b0, 4'd3, 5'd0, 6'h20}), 0, 0, 1'b0);
        run_instr(mk(OPC_LW, 4'd1, 4'd5, 16'd4), 0, 3, 1'b0);

        // Directed: BEQ taken and not taken
        run_instr(mk(OPC_BEQ, 4'd2, 4'd2, 16'h0010), 0, 0, 1'b1);
        run_instr(mk(OPC_BEQ, 4'd2, 4'd7, 16'h0010), 0, 0, 1'b0);

        // Directed: undefined opcode 6'h15
        run_instr(mk(6'h15, 4'd6, 4'd9, 16'hBEEF), 0, 0, 1'b0);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        do_reset();
`else
        run_instr(mk(OPC_ADDI, 4'd1, 4'd4, 16'h0007), 0, 0, 1'b0);
`endif

        // Directed: J then HALT, then HALT must stay quiet
        run_instr(mk(OPC_J, 4'd0, 4'd0, 16'h0100), 0, 0, 1'b0);
        run_instr(mk(OPC_HLT, 4'd0, 4'd0, 16'h0000), 1, 0, 1'b0);
        instr_valid = 1'b1;
        mem_ready   = 1'b1;
        strobe_hits = 0;
        halt_lows   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ir_load || pc_write || reg_write || mem_read || mem_write) strobe_hits++;
            if (!halted) halt_lows++;
        end
        check("halt_strobes", 64'(strobe_hits), 64'd0);
        check("halt_held", 64'(halt_lows), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
